wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 20 ++
 rtl/wb_port_arbiter_rr_pick3.sv | 29 ++
 rtl/wb_port_arbiter.sv | 93 +++++++++
 tb/tb_wb_port_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared MIPS write-back constants: mux select encodings, $zero register,
// requester count and the round-robin pointer advance helper.
package wb_port_arbiter_pkg;

   localparam int unsigned NUM_REQ  = 3;
   localparam logic [4:0]  REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      SEL_ALU  = 2'b00,
      SEL_MEM  = 2'b01,
      SEL_LINK = 2'b10,
      SEL_IDLE = 2'b11
   } sel_e;

   // Pointer moves to the requester just after the one granted, wrapping mod 3.
   function automatic logic [1:0] next_ptr(input logic [1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: scans ptr, ptr+1, ptr+2 (mod 3)
// and reports the first requester found.
module rr_pick3
   import wb_port_arbiter_pkg::*;
(
   input  logic [2:0] i_req,
   input  logic [1:0] i_ptr,
   output logic       o_valid,
   output logic [1:0] o_idx
);

   int unsigned w_cand;

   // First set request in rotated order starting at the pointer.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = 2'd0;
      w_cand  = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_cand = 32'(i_ptr) + k;
         if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
         if (!o_valid && i_req[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = 2'(w_cand);
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-back port arbiter: round-robin over ALU, MEM load and
// LINK requesters with registered grant, mux select and write controls.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic [4:0] addr0,
   input  logic [4:0] addr1,
   input  logic [4:0] addr2,
   input  logic       stall,
   output logic [2:0] grant,
   output logic [1:0] select,
   output logic       reg_write,
   output logic [4:0] write_reg
);

   logic [2:0] r_grant;
   sel_e       r_select;
   logic       r_reg_write;
   logic [4:0] r_write_reg;
   logic [1:0] r_ptr;

   logic [2:0] w_req_masked;
   logic       w_valid;
   logic [1:0] w_idx;
   logic [4:0] w_addr;
   logic [2:0] w_grant_nxt;
   sel_e       w_select_nxt;
   logic       w_reg_write_nxt;
   logic [4:0] w_write_reg_nxt;
   logic [1:0] w_ptr_nxt;

   // A request whose grant is currently showing is already being served.
   assign w_req_masked = req & ~r_grant;

   rr_pick3 u_pick (
      .i_req   (w_req_masked),
      .i_ptr   (r_ptr),
      .o_valid (w_valid),
      .o_idx   (w_idx)
   );

   // Next grant, select, write controls and pointer from the picker result.
   always_comb begin
      w_grant_nxt     = 3'b000;
      w_select_nxt    = SEL_IDLE;
      w_reg_write_nxt = 1'b0;
      w_write_reg_nxt = REG_ZERO;
      w_ptr_nxt       = r_ptr;
      w_addr          = REG_ZERO;
      case (w_idx)
         2'd0:    w_addr = addr0;
         2'd1:    w_addr = addr1;
         2'd2:    w_addr = addr2;
         default: w_addr = REG_ZERO;
      endcase
      if (w_valid) begin
         w_grant_nxt  = 3'b001 << w_idx;
         w_select_nxt = sel_e'(w_idx);
         w_ptr_nxt    = next_ptr(w_idx);
         // $zero still takes the grant slot but never writes the file.
         if (w_addr != REG_ZERO) begin
            w_reg_write_nxt = 1'b1;
            w_write_reg_nxt = w_addr;
         end
      end
   end

   // Output/pointer registers; reset beats stall, stall freezes everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant     <= 3'b000;
         r_select    <= SEL_IDLE;
         r_reg_write <= 1'b0;
         r_write_reg <= REG_ZERO;
         r_ptr       <= 2'd0;
      end else if (!stall) begin
         r_grant     <= w_grant_nxt;
         r_select    <= w_select_nxt;
         r_reg_write <= w_reg_write_nxt;
         r_write_reg <= w_write_reg_nxt;
         r_ptr       <= w_ptr_nxt;
      end
   end

   assign grant     = r_grant;
   assign select    = r_select;
   assign reg_write = r_reg_write;
   assign write_reg = r_write_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: each step pushes its hand-derived
// expected outputs to a scoreboard and pops/compares after the clock edge.
module tb_wb_port_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] req = 3'b000;
   logic [4:0] addr0 = 5'd0;
   logic [4:0] addr1 = 5'd0;
   logic [4:0] addr2 = 5'd0;
   logic       stall = 1'b0;
   logic [2:0] grant;
   logic [1:0] select;
   logic       reg_write;
   logic [4:0] write_reg;

   typedef struct packed {
      logic [2:0] g;
      logic [1:0] s;
      logic       rw;
      logic [4:0] wr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   wb_port_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .addr0     (addr0),
      .addr1     (addr1),
      .addr2     (addr2),
      .stall     (stall),
      .grant     (grant),
      .select    (select),
      .reg_write (reg_write),
      .write_reg (write_reg)
   );

   always #5 clk = ~clk;

   task automatic compare(input string tag, input logic [4:0] obs, input logic [4:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(input string name);
      exp_t e;
      logic ok1, ok2;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL %s_sb_empty observed=0 expected=1", name);
         return;
      end
      e = sb.pop_front();
      compare({name, "_grant"},     {2'b00, grant},     {2'b00, e.g});
      compare({name, "_select"},    {3'b000, select},   {3'b000, e.s});
      compare({name, "_reg_write"}, {4'b0000, reg_write}, {4'b0000, e.rw});
      compare({name, "_write_reg"}, write_reg,          e.wr);
      ok1 = $onehot0(grant);
      ok2 = ((select == 2'b11) == (grant == 3'b000));
      compare({name, "_onehot"},    {4'b0000, ok1}, 5'd1);
      compare({name, "_idle_sel"},  {4'b0000, ok2}, 5'd1);
   endtask

   task automatic step(input string name, input logic rst, input logic stl,
                       input logic [2:0] rq, input logic [2:0] eg,
                       input logic [1:0] es, input logic erw, input logic [4:0] ewr);
      @(negedge clk);
      reset = rst;
      stall = stl;
      req   = rq;
      sb.push_back('{g: eg, s: es, rw: erw, wr: ewr});
      @(posedge clk);
      #1;
      check_outputs(name);
   endtask

   initial begin
      // Reset, then idle cycles.
      step("rst",    1'b1, 1'b0, 3'b000, 3'b000, 2'b11, 1'b0, 5'd0);
      step("idle0",  1'b0, 1'b0, 3'b000, 3'b000, 2'b11, 1'b0, 5'd0);
      step("idle1",  1'b0, 1'b0, 3'b000, 3'b000, 2'b11, 1'b0, 5'd0);
      step("idle2",  1'b0, 1'b0, 3'b000, 3'b000, 2'b11, 1'b0, 5'd0);

      // All three request, each drops on seeing its grant.
      addr0 = 5'd5; addr1 = 5'd9; addr2 = 5'd31;
      step("rr0",    1'b0, 1'b0, 3'b111, 3'b001, 2'b00, 1'b1, 5'd5);
      step("rr1",    1'b0, 1'b0, 3'b110, 3'b010, 2'b01, 1'b1, 5'd9);
      step("rr2",    1'b0, 1'b0, 3'b100, 3'b100, 2'b10, 1'b1, 5'd31);
      step("rr_end", 1'b0, 1'b0, 3'b000, 3'b000, 2'b11, 1'b0, 5'd0);

      // Continuous MEM request is served every other cycle.
      addr1 = 5'd12;
      step("cont0",  1'b0, 1'b0, 3'b010, 3'b010, 2'b01, 1'b1, 5'd12);
      step("cont1",  1'b0, 1'b0, 3'b010, 3'b000, 2'b11, 1'b0, 5'd0);
      step("cont2",  1'b0, 1'b0, 3'b010, 3'b010, 2'b01, 1'b1, 5'd12);
      step("cont3",  1'b0, 1'b0, 3'b010, 3'b000, 2'b11, 1'b0, 5'd0);
      step("cont_e", 1'b0, 1'b0, 3'b000, 3'b000, 2'b11, 1'b0, 5'd0);

      // $zero destination: grant issued, no write; ptr 2 -> 1.
      addr0 = 5'd0;
      step("zero",   1'b0, 1'b0, 3'b001, 3'b001, 2'b00, 1'b0, 5'd0);
      step("zero_e", 1'b0, 1'b0, 3'b000, 3'b000, 2'b11, 1'b0, 5'd0);

      // Stall holds a MEM grant; afterwards ptr=2 favours LINK over ALU.
      addr0 = 5'd5; addr1 = 5'd9;
      step("pre_st", 1'b0, 1'b0, 3'b010, 3'b010, 2'b01, 1'b1, 5'd9);
      step("stall0", 1'b0, 1'b1, 3'b101, 3'b010, 2'b01, 1'b1, 5'd9);
      step("stall1", 1'b0, 1'b1, 3'b101, 3'b010, 2'b01, 1'b1, 5'd9);
      step("post_st",1'b0, 1'b0, 3'b101, 3'b100, 2'b10, 1'b1, 5'd31);

      // Reset with stall during a LINK grant, then restart from ptr 0.
      step("rst_st", 1'b1, 1'b1, 3'b111, 3'b000, 2'b11, 1'b0, 5'd0);
      step("rst_g0", 1'b0, 1'b0, 3'b111, 3'b001, 2'b00, 1'b1, 5'd5);
      // ptr is 1 here; reset must return it to 0.
      step("rst2",   1'b1, 1'b0, 3'b111, 3'b000, 2'b11, 1'b0, 5'd0);
      step("rst2_g", 1'b0, 1'b0, 3'b111, 3'b001, 2'b00, 1'b1, 5'd5);
      step("rst2_n", 1'b0, 1'b0, 3'b110, 3'b010, 2'b01, 1'b1, 5'd9);
      step("final",  1'b0, 1'b0, 3'b000, 3'b000, 2'b11, 1'b0, 5'd0);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
